product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/acc_pkg.sv | 14 +
 rtl/acc_sat_add.sv | 24 ++
 rtl/product_accumulator.sv | 94 +++++++++
 tb/tb_product_accumulator.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared types and default sizing for the product accumulator.
package acc_pkg;

    localparam int N_DEF         = 6;
    localparam int ACC_W_DEF     = 12;
    localparam int CNT_W_DEF     = 4;
    localparam int MAX_TERMS_DEF = 8;

    typedef enum logic {
        ACC  = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/acc_sat_add.sv
// ACC_W adder with carry-out; clamps to all-ones when ACC_SATURATE_EN is defined.
module acc_sat_add #(
    parameter int N     = 6,
    parameter int ACC_W = 12
) (
    input  logic [ACC_W-1:0] i_a,
    input  logic [N-1:0]     i_b,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_carry
);

    logic [ACC_W:0] w_full;

    assign w_full  = {1'b0, i_a} + (ACC_W + 1)'(i_b);
    assign o_carry = w_full[ACC_W];

`ifdef ACC_SATURATE_EN
    // A clamped accumulator stays clamped: any further nonzero term carries again.
    assign o_sum = o_carry ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
    assign o_sum = w_full[ACC_W-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// Groups products into sums with term count and sticky overflow.
// Optional ACC_SATURATE_EN clamps the sum instead of wrapping.
module product_accumulator
    import acc_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int MAX_TERMS = MAX_TERMS_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             recv_val,
    output logic             recv_rdy,
    input  logic [N-1:0]     recv_msg,
    input  logic             recv_last,
    output logic             send_val,
    input  logic             send_rdy,
    output logic [ACC_W-1:0] send_msg,
    output logic [CNT_W-1:0] send_cnt,
    output logic             send_ovf
);

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic               r_send_val;

    logic               w_accept;
    logic               w_close;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [ACC_W-1:0]   w_sum;
    logic               w_carry;

    acc_sat_add #(
        .N     (N),
        .ACC_W (ACC_W)
    ) u_add (
        .i_a     (r_acc),
        .i_b     (recv_msg),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    assign recv_rdy  = rst_n && (r_state == ACC);
    assign w_accept  = recv_val && recv_rdy;
    assign w_cnt_nxt = r_cnt + 1'b1;
    assign w_close   = recv_last || (w_cnt_nxt == CNT_W'(MAX_TERMS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ACC;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_send_val <= 1'b0;
        end else begin
            unique case (r_state)
                ACC: begin
                    if (w_accept) begin
                        r_acc <= w_sum;
                        r_cnt <= w_cnt_nxt;
                        r_ovf <= r_ovf | w_carry;
                        if (w_close) begin
                            r_state    <= SEND;
                            r_send_val <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    // No bypass: the handshake cycle never accepts a term.
                    if (send_rdy) begin
                        r_state    <= ACC;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_ovf      <= 1'b0;
                        r_send_val <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ACC;
                    r_send_val <= 1'b0;
                end
            endcase
        end
    end

    assign send_val = r_send_val;
    assign send_msg = r_acc;
    assign send_cnt = r_cnt;
    assign send_ovf = r_ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed table vectors, corner sequences and a random scoreboard run.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        recv_val, recv_rdy, recv_last;
    logic [5:0]  recv_msg;
    logic        send_val, send_rdy, send_ovf;
    logic [11:0] send_msg;
    logic [3:0]  send_cnt;

    logic        r7_val, r7_rdy, r7_last;
    logic [5:0]  r7_msg;
    logic        s7_val, s7_rdy, s7_ovf;
    logic [6:0]  s7_msg;
    logic [3:0]  s7_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    product_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .recv_val  (recv_val),
        .recv_rdy  (recv_rdy),
        .recv_msg  (recv_msg),
        .recv_last (recv_last),
        .send_val  (send_val),
        .send_rdy  (send_rdy),
        .send_msg  (send_msg),
        .send_cnt  (send_cnt),
        .send_ovf  (send_ovf)
    );

    product_accumulator #(.ACC_W(7)) dut7 (
        .clk       (clk),
        .rst_n     (rst_n),
        .recv_val  (r7_val),
        .recv_rdy  (r7_rdy),
        .recv_msg  (r7_msg),
        .recv_last (r7_last),
        .send_val  (s7_val),
        .send_rdy  (s7_rdy),
        .send_msg  (s7_msg),
        .send_cnt  (s7_cnt),
        .send_ovf  (s7_ovf)
    );

    typedef struct packed {
        logic [3:0]      n;
        logic [7:0][5:0] t;
        logic [3:0]      last_idx;
        logic [11:0]     msg;
        logic [3:0]      cnt;
        logic            ovf;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [5:0] m, input logic l);
        recv_val  = 1'b1;
        recv_msg  = m;
        recv_last = l;
        tick();
        recv_val  = 1'b0;
        recv_last = 1'b0;
    endtask

    task automatic put7(input logic [5:0] m, input logic l);
        r7_val  = 1'b1;
        r7_msg  = m;
        r7_last = l;
        tick();
        r7_val  = 1'b0;
        r7_last = 1'b0;
    endtask

    task automatic wait_send(input int lim, output bit ok);
        int k;
        k = 0;
        while (send_val !== 1'b1 && k < lim) begin
            tick();
            k++;
        end
        ok = (send_val === 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned exp_sum;
        int          exp_cnt;
        bit          ok;
        int          len;
        bit          use_last;
        logic [5:0]  m;

        vecs[0] = '{n: 4'd3, t: {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd7, 6'd5, 6'd3},
                    last_idx: 4'd2, msg: 12'd15, cnt: 4'd3, ovf: 1'b0};
        vecs[1] = '{n: 4'd8, t: {8{6'd63}},
                    last_idx: 4'd8, msg: 12'd504, cnt: 4'd8, ovf: 1'b0};
        vecs[2] = '{n: 4'd8, t: {8{6'd63}},
                    last_idx: 4'd7, msg: 12'd504, cnt: 4'd8, ovf: 1'b0};
        vecs[3] = '{n: 4'd1, t: {7'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd42},
                    last_idx: 4'd0, msg: 12'd42, cnt: 4'd1, ovf: 1'b0};
        vecs[4] = '{n: 4'd2, t: '0,
                    last_idx: 4'd1, msg: 12'd0, cnt: 4'd2, ovf: 1'b0};
        vecs[5] = '{n: 4'd8, t: {6'd8, 6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1},
                    last_idx: 4'd8, msg: 12'd36, cnt: 4'd8, ovf: 1'b0};
        vecs[6] = '{n: 4'd2, t: {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd1, 6'd63},
                    last_idx: 4'd1, msg: 12'd64, cnt: 4'd2, ovf: 1'b0};

        rst_n     = 1'b0;
        recv_val  = 1'b0;
        recv_msg  = '0;
        recv_last = 1'b0;
        send_rdy  = 1'b1;
        r7_val    = 1'b0;
        r7_msg    = '0;
        r7_last   = 1'b0;
        s7_rdy    = 1'b1;

        tick();
        chk("rst_rdy_low", recv_rdy, 1'b0);
        chk("rst_val_low", send_val, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_rdy", recv_rdy, 1'b1);
        chk("post_rst_val", send_val, 1'b0);
        chk("post_rst_msg", send_msg, 12'd0);
        chk("post_rst_cnt", send_cnt, 4'd0);

        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < int'(vecs[i].n); j++)
                put(vecs[i].t[j], j == int'(vecs[i].last_idx));
            chk($sformatf("vec%0d_val", i), send_val, 1'b1);
            chk($sformatf("vec%0d_msg", i), send_msg, vecs[i].msg);
            chk($sformatf("vec%0d_cnt", i), send_cnt, vecs[i].cnt);
            chk($sformatf("vec%0d_ovf", i), send_ovf, vecs[i].ovf);
            tick();
            chk($sformatf("vec%0d_done", i), send_val, 1'b0);
            chk($sformatf("vec%0d_rdy", i), recv_rdy, 1'b1);
        end

        put7(6'd63, 1'b0);
        put7(6'd63, 1'b0);
        put7(6'd63, 1'b1);
        chk("w7_val", s7_val, 1'b1);
`ifdef ACC_SATURATE_EN
        chk("w7_msg", s7_msg, 7'd127);
`else
        chk("w7_msg", s7_msg, 7'd61);
`endif
        chk("w7_cnt", s7_cnt, 4'd3);
        chk("w7_ovf", s7_ovf, 1'b1);
        tick();
        put7(6'd10, 1'b0);
        put7(6'd20, 1'b1);
        chk("w7_next_msg", s7_msg, 7'd30);
        chk("w7_next_ovf", s7_ovf, 1'b0);
        tick();

        send_rdy = 1'b0;
        put(6'd1, 1'b0);
        put(6'd2, 1'b1);
        recv_val  = 1'b1;
        recv_msg  = 6'd9;
        recv_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_rdy", recv_rdy, 1'b0);
            chk("hold_val", send_val, 1'b1);
            chk("hold_msg", send_msg, 12'd3);
            chk("hold_cnt", send_cnt, 4'd2);
        end
        send_rdy = 1'b1;
        tick();
        chk("hs_val", send_val, 1'b0);
        chk("hs_rdy", recv_rdy, 1'b1);
        tick();
        recv_val  = 1'b0;
        recv_last = 1'b0;
        chk("held_term_val", send_val, 1'b1);
        chk("held_term_msg", send_msg, 12'd9);
        chk("held_term_cnt", send_cnt, 4'd1);
        tick();

        put(6'd10, 1'b0);
        put(6'd20, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_rdy", recv_rdy, 1'b0);
        chk("midrst_val", send_val, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("midrst_after", send_val, 1'b0);
        put(6'd5, 1'b1);
        chk("midrst_msg", send_msg, 12'd5);
        chk("midrst_cnt", send_cnt, 4'd1);
        tick();
        send_rdy = 1'b0;
        put(6'd7, 1'b1);
        chk("sendrst_pre", send_val, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("sendrst_val", send_val, 1'b0);
        @(negedge clk);
        rst_n    = 1'b1;
        send_rdy = 1'b1;
        tick();
        chk("sendrst_after", send_val, 1'b0);
        put(6'd3, 1'b1);
        chk("sendrst_msg", send_msg, 12'd3);
        chk("sendrst_cnt", send_cnt, 4'd1);
        tick();

        for (int g = 0; g < 20; g++) begin
            len      = int'($urandom_range(1, 8));
            use_last = (len < 8) ? 1'b1 : 1'($urandom_range(0, 1));
            exp_sum  = 0;
            exp_cnt  = 0;
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    recv_msg  = 6'($urandom);
                    recv_last = 1'($urandom_range(0, 1));
                    tick();
                end
                recv_last = 1'b0;
                m = 6'($urandom);
                exp_sum += m;
                exp_cnt++;
                put(m, use_last && (i == len - 1));
            end
            wait_send(4, ok);
            chk("rnd_val", 32'(ok), 32'd1);
            chk("rnd_msg", send_msg, 32'(exp_sum % 4096));
            chk("rnd_cnt", send_cnt, 32'(exp_cnt));
            chk("rnd_ovf", send_ovf, 32'(exp_sum > 4095));
            send_rdy = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
            chk("rnd_hold", send_msg, 32'(exp_sum % 4096));
            send_rdy = 1'b1;
            tick();
            chk("rnd_done", send_val, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
